v_lsu_agu: RTL and testbench

V_LSU_AGU -- requirements
Module: v_lsu_agu

---
 rtl/v_lsu_agu.sv | 243 ++++++++++++++++++++++++
 tb/tb_v_lsu_agu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_lsu_agu.sv
// Strided vector load/store address generator for a 4-bank word memory.
// Each issue cycle takes the longest run of upcoming elements whose banks do not collide.
//
//   state | meaning
//   IDLE  | waiting for start; a start with vl=0 only pulses done
//   ISSUE | issuing up to 4 bank-distinct elements per cycle
//   DRAIN | final load writeback cycle; done follows
module v_lsu_agu #(
    parameter int DATAMEM_BITS  = 14,
    parameter int DATAMEM_WIDTH = 32,
    parameter int VL_BITS       = 7
) (
    input  logic                     core_clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [DATAMEM_BITS-1:0]  base_addr,
    input  logic [DATAMEM_BITS-1:0]  stride,
    input  logic [VL_BITS-1:0]       vl,
    output logic [5:0]               st_idx_0,
    output logic [5:0]               st_idx_1,
    output logic [5:0]               st_idx_2,
    output logic [5:0]               st_idx_3,
    input  logic [DATAMEM_WIDTH-1:0] st_data_0,
    input  logic [DATAMEM_WIDTH-1:0] st_data_1,
    input  logic [DATAMEM_WIDTH-1:0] st_data_2,
    input  logic [DATAMEM_WIDTH-1:0] st_data_3,
    output logic [3:0]               dm_write_0,
    output logic [3:0]               dm_write_1,
    output logic [3:0]               dm_write_2,
    output logic [3:0]               dm_write_3,
    output logic [DATAMEM_BITS-1:0]  data_addr,
    output logic [DATAMEM_BITS-1:0]  data_addr1,
    output logic [DATAMEM_BITS-1:0]  data_addr2,
    output logic [DATAMEM_BITS-1:0]  data_addr3,
    output logic [DATAMEM_WIDTH-1:0] data_in_0,
    output logic [DATAMEM_WIDTH-1:0] data_in_1,
    output logic [DATAMEM_WIDTH-1:0] data_in_2,
    output logic [DATAMEM_WIDTH-1:0] data_in_3,
    input  logic [DATAMEM_WIDTH-1:0] data_out_0,
    input  logic [DATAMEM_WIDTH-1:0] data_out_1,
    input  logic [DATAMEM_WIDTH-1:0] data_out_2,
    input  logic [DATAMEM_WIDTH-1:0] data_out_3,
    output logic [3:0]               ld_we,
    output logic [5:0]               ld_idx_0,
    output logic [5:0]               ld_idx_1,
    output logic [5:0]               ld_idx_2,
    output logic [5:0]               ld_idx_3,
    output logic [DATAMEM_WIDTH-1:0] ld_data_0,
    output logic [DATAMEM_WIDTH-1:0] ld_data_1,
    output logic [DATAMEM_WIDTH-1:0] ld_data_2,
    output logic [DATAMEM_WIDTH-1:0] ld_data_3,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = DATAMEM_BITS - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                   state;
    logic                     op_store;
    logic [AW-1:0]            cur_addr;
    logic [AW-1:0]            stride_r;
    logic [VL_BITS-1:0]       cur_idx;
    logic [VL_BITS-1:0]       vl_r;

    logic [VL_BITS-1:0]       remaining;
    logic [AW-1:0]            lane_addr [4];
    logic [1:0]               lane_bank [4];
    logic [5:0]               lane_idx  [4];
    logic [3:0]               issue_mask;
    logic [2:0]               issue_cnt;
    logic                     last_issue;
    logic [AW-1:0]            next_addr;

    logic [AW-1:0]            addr_hold [4];
    logic [AW-1:0]            bank_addr [4];
    logic [3:0]               bank_we   [4];
    logic [DATAMEM_WIDTH-1:0] bank_din  [4];
    logic [5:0]               st_idx_arr [4];
    logic [DATAMEM_WIDTH-1:0] st_data   [4];
    logic [DATAMEM_WIDTH-1:0] dout      [4];

    logic [5:0]               ld_idx_r  [4];
    logic [1:0]               ld_bank_r [4];
    logic [DATAMEM_WIDTH-1:0] ld_data_arr [4];

    logic                     unused_msb;

    // Address bit 13 is never driven, so the top bits of base/stride do not matter.
    assign unused_msb = base_addr[AW] ^ stride[AW];

    assign st_data[0] = st_data_0;
    assign st_data[1] = st_data_1;
    assign st_data[2] = st_data_2;
    assign st_data[3] = st_data_3;
    assign dout[0]    = data_out_0;
    assign dout[1]    = data_out_1;
    assign dout[2]    = data_out_2;
    assign dout[3]    = data_out_3;

    always_comb begin : issue_select
        remaining  = vl_r - cur_idx;
        issue_mask = '0;
        for (int j = 0; j < 4; j++) begin
            lane_addr[j] = cur_addr + AW'(j) * stride_r;
            lane_bank[j] = lane_addr[j][1:0];
            lane_idx[j]  = cur_idx[5:0] + 6'(j);
        end
        if (state == ISSUE) begin
            issue_mask[0] = 1'b1;
            issue_mask[1] = (remaining > VL_BITS'(1)) && (lane_bank[1] != lane_bank[0]);
            issue_mask[2] = issue_mask[1] && (remaining > VL_BITS'(2)) &&
                            (lane_bank[2] != lane_bank[0]) && (lane_bank[2] != lane_bank[1]);
            issue_mask[3] = issue_mask[2] && (remaining > VL_BITS'(3)) &&
                            (lane_bank[3] != lane_bank[0]) && (lane_bank[3] != lane_bank[1]) &&
                            (lane_bank[3] != lane_bank[2]);
        end
    end

    always_comb begin : issue_advance
        issue_cnt  = 3'(issue_mask[0]) + 3'(issue_mask[1]) + 3'(issue_mask[2]) + 3'(issue_mask[3]);
        last_issue = (state == ISSUE) && (remaining <= VL_BITS'(issue_cnt));
        next_addr  = cur_addr + AW'(issue_cnt) * stride_r;
    end

    // Banks not touched this cycle keep presenting their previous address.
    always_comb begin : bank_route
        for (int k = 0; k < 4; k++) begin
            bank_addr[k] = addr_hold[k];
            bank_we[k]   = 4'h0;
            bank_din[k]  = '0;
            for (int j = 0; j < 4; j++) begin
                if (issue_mask[j] && (lane_bank[j] == 2'(k))) begin
                    bank_addr[k] = lane_addr[j];
                    if (op_store) begin
                        bank_we[k]  = 4'hF;
                        bank_din[k] = st_data[j];
                    end
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            st_idx_arr[j]  = (op_store && issue_mask[j]) ? lane_idx[j] : 6'd0;
            ld_data_arr[j] = ld_we[j] ? dout[ld_bank_r[j]] : '0;
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            op_store <= 1'b0;
            cur_addr <= '0;
            stride_r <= '0;
            cur_idx  <= '0;
            vl_r     <= '0;
            ld_we    <= 4'h0;
            for (int k = 0; k < 4; k++) begin
                addr_hold[k] <= '0;
                ld_idx_r[k]  <= '0;
                ld_bank_r[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                addr_hold[k] <= bank_addr[k];
            end
            for (int j = 0; j < 4; j++) begin
                ld_we[j]     <= issue_mask[j] && !op_store;
                ld_idx_r[j]  <= (issue_mask[j] && !op_store) ? lane_idx[j] : 6'd0;
                ld_bank_r[j] <= (issue_mask[j] && !op_store) ? lane_bank[j] : 2'd0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (vl == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            busy     <= 1'b1;
                            op_store <= is_store;
                            cur_addr <= base_addr[AW-1:0];
                            stride_r <= stride[AW-1:0];
                            cur_idx  <= '0;
                            vl_r     <= vl;
                        end
                    end
                end
                ISSUE: begin
                    cur_idx  <= cur_idx + VL_BITS'(issue_cnt);
                    cur_addr <= next_addr;
                    if (last_issue) begin
                        if (op_store) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign st_idx_0   = st_idx_arr[0];
    assign st_idx_1   = st_idx_arr[1];
    assign st_idx_2   = st_idx_arr[2];
    assign st_idx_3   = st_idx_arr[3];
    assign dm_write_0 = bank_we[0];
    assign dm_write_1 = bank_we[1];
    assign dm_write_2 = bank_we[2];
    assign dm_write_3 = bank_we[3];
    assign data_addr  = {1'b0, bank_addr[0]};
    assign data_addr1 = {1'b0, bank_addr[1]};
    assign data_addr2 = {1'b0, bank_addr[2]};
    assign data_addr3 = {1'b0, bank_addr[3]};
    assign data_in_0  = bank_din[0];
    assign data_in_1  = bank_din[1];
    assign data_in_2  = bank_din[2];
    assign data_in_3  = bank_din[3];
    assign ld_idx_0   = ld_idx_r[0];
    assign ld_idx_1   = ld_idx_r[1];
    assign ld_idx_2   = ld_idx_r[2];
    assign ld_idx_3   = ld_idx_r[3];
    assign ld_data_0  = ld_data_arr[0];
    assign ld_data_1  = ld_data_arr[1];
    assign ld_data_2  = ld_data_arr[2];
    assign ld_data_3  = ld_data_arr[3];

endmodule

// File: tb/tb_v_lsu_agu.sv
// Scoreboard bench for v_lsu_agu: stimulus pushes expected memory writes, load
// writebacks and done pulses, each stamped with its cycle; a negedge monitor pops and compares.
module tb_v_lsu_agu;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;   // 0 store write, 1 load writeback, 2 done
        logic [1:0]  unit;
        logic [3:0]  we;
        logic [13:0] addr;
        logic [5:0]  idx;
        logic [31:0] data;
    } ev_t;

    logic        core_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [13:0] base_addr = '0;
    logic [13:0] stride = '0;
    logic [6:0]  vl = '0;
    logic [5:0]  st_idx_0, st_idx_1, st_idx_2, st_idx_3;
    logic [31:0] st_data_0, st_data_1, st_data_2, st_data_3;
    logic [3:0]  dm_write_0, dm_write_1, dm_write_2, dm_write_3;
    logic [13:0] data_addr, data_addr1, data_addr2, data_addr3;
    logic [31:0] data_in_0, data_in_1, data_in_2, data_in_3;
    logic [31:0] data_out_0 = '0, data_out_1 = '0, data_out_2 = '0, data_out_3 = '0;
    logic [3:0]  ld_we;
    logic [5:0]  ld_idx_0, ld_idx_1, ld_idx_2, ld_idx_3;
    logic [31:0] ld_data_0, ld_data_1, ld_data_2, ld_data_3;
    logic        busy, done;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  q[$];
    logic [31:0] mem [8192];

    logic [3:0]  dmw  [4];
    logic [13:0] da   [4];
    logic [31:0] din  [4];
    logic [5:0]  lidx [4];
    logic [31:0] ldat [4];

    assign dmw[0] = dm_write_0;  assign dmw[1] = dm_write_1;
    assign dmw[2] = dm_write_2;  assign dmw[3] = dm_write_3;
    assign da[0]  = data_addr;   assign da[1]  = data_addr1;
    assign da[2]  = data_addr2;  assign da[3]  = data_addr3;
    assign din[0] = data_in_0;   assign din[1] = data_in_1;
    assign din[2] = data_in_2;   assign din[3] = data_in_3;
    assign lidx[0] = ld_idx_0;   assign lidx[1] = ld_idx_1;
    assign lidx[2] = ld_idx_2;   assign lidx[3] = ld_idx_3;
    assign ldat[0] = ld_data_0;  assign ldat[1] = ld_data_1;
    assign ldat[2] = ld_data_2;  assign ldat[3] = ld_data_3;

    // Register file stand-in: store element i carries 0x5700_0000 | i.
    assign st_data_0 = 32'h5700_0000 | {26'd0, st_idx_0};
    assign st_data_1 = 32'h5700_0000 | {26'd0, st_idx_1};
    assign st_data_2 = 32'h5700_0000 | {26'd0, st_idx_2};
    assign st_data_3 = 32'h5700_0000 | {26'd0, st_idx_3};

    v_lsu_agu dut (
        .core_clk(core_clk), .rst(rst), .start(start), .is_store(is_store),
        .base_addr(base_addr), .stride(stride), .vl(vl),
        .st_idx_0(st_idx_0), .st_idx_1(st_idx_1), .st_idx_2(st_idx_2), .st_idx_3(st_idx_3),
        .st_data_0(st_data_0), .st_data_1(st_data_1), .st_data_2(st_data_2), .st_data_3(st_data_3),
        .dm_write_0(dm_write_0), .dm_write_1(dm_write_1), .dm_write_2(dm_write_2), .dm_write_3(dm_write_3),
        .data_addr(data_addr), .data_addr1(data_addr1), .data_addr2(data_addr2), .data_addr3(data_addr3),
        .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3),
        .ld_we(ld_we),
        .ld_idx_0(ld_idx_0), .ld_idx_1(ld_idx_1), .ld_idx_2(ld_idx_2), .ld_idx_3(ld_idx_3),
        .ld_data_0(ld_data_0), .ld_data_1(ld_data_1), .ld_data_2(ld_data_2), .ld_data_3(ld_data_3),
        .busy(busy), .done(done)
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) cyc <= cyc + 1;

    // Banked memory: synchronous read, full-word write.
    always @(posedge core_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (dmw[k] == 4'hF) mem[da[k][12:0]] <= din[k];
        end
        data_out_0 <= mem[data_addr[12:0]];
        data_out_1 <= mem[data_addr1[12:0]];
        data_out_2 <= mem[data_addr2[12:0]];
        data_out_3 <= mem[data_addr3[12:0]];
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic void exp_st(int c, int bank, logic [13:0] addr, int idx);
        q.push_back('{32'(c), 2'd0, 2'(bank), 4'hF, addr, 6'd0, 32'h5700_0000 | 32'(idx)});
    endfunction

    function automatic void exp_ld(int c, int lane, int idx, logic [31:0] data);
        q.push_back('{32'(c), 2'd1, 2'(lane), 4'h0, 14'h0, 6'(idx), data});
    endfunction

    function automatic void exp_done(int c);
        q.push_back('{32'(c), 2'd2, 2'd0, 4'h0, 14'h0, 6'd0, 32'h0});
    endfunction

    function automatic void got(ev_t a);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got cyc=%0d kind=%0d unit=%0d we=%h addr=%h idx=%0d data=%h, required no event",
                     a.cyc, a.kind, a.unit, a.we, a.addr, a.idx, a.data);
            return;
        end
        e = q.pop_front();
        if (a != e) begin
            failures++;
            $display("FAIL sb_event: got cyc=%0d kind=%0d unit=%0d we=%h addr=%h idx=%0d data=%h, required cyc=%0d kind=%0d unit=%0d we=%h addr=%h idx=%0d data=%h",
                     a.cyc, a.kind, a.unit, a.we, a.addr, a.idx, a.data,
                     e.cyc, e.kind, e.unit, e.we, e.addr, e.idx, e.data);
        end
    endfunction

    always @(negedge core_clk) begin
        while (q.size() > 0 && q[0].cyc < 32'(cyc)) begin
            checks++;
            failures++;
            $display("FAIL sb_missing: got nothing at cyc=%0d, required kind=%0d unit=%0d idx=%0d data=%h",
                     q[0].cyc, q[0].kind, q[0].unit, q[0].idx, q[0].data);
            void'(q.pop_front());
        end
        for (int k = 0; k < 4; k++) begin
            if (dmw[k] != 4'h0) got('{32'(cyc), 2'd0, 2'(k), dmw[k], da[k], 6'd0, din[k]});
        end
        for (int j = 0; j < 4; j++) begin
            if (ld_we[j]) got('{32'(cyc), 2'd1, 2'(j), 4'h0, 14'h0, lidx[j], ldat[j]});
        end
        if (done) got('{32'(cyc), 2'd2, 2'd0, 4'h0, 14'h0, 6'd0, 32'h0});
    end

    task automatic chk_all_zero(string p);
        chk({p, "_ctrl"}, 64'({busy, done, ld_we}), 64'h0);
        chk({p, "_we"},   64'({dm_write_0, dm_write_1, dm_write_2, dm_write_3}), 64'h0);
        chk({p, "_addr"}, 64'({data_addr, data_addr1, data_addr2, data_addr3}), 64'h0);
        chk({p, "_idx"},  64'({st_idx_0, st_idx_1, st_idx_2, st_idx_3, ld_idx_0, ld_idx_1, ld_idx_2, ld_idx_3}), 64'h0);
        chk({p, "_data"}, 64'(|{data_in_0, data_in_1, data_in_2, data_in_3,
                               ld_data_0, ld_data_1, ld_data_2, ld_data_3}), 64'h0);
    endtask

    // Called at a negedge; s is the cycle stamp of the first issue cycle.
    task automatic begin_op(input logic st, input logic [13:0] b, input logic [13:0] sd,
                            input logic [6:0] n, output int s);
        is_store  = st;
        base_addr = b;
        stride    = sd;
        vl        = n;
        start     = 1'b1;
        s         = cyc + 1;
    endtask

    task automatic end_op();
        @(negedge core_clk);
        start = 1'b0;
    endtask

    initial begin
        int s;
        for (int a = 0; a < 8192; a++) mem[a] = 32'hD000_0000 | 32'(a);
        @(negedge core_clk);
        @(negedge core_clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge core_clk);

        // load 0x010 stride 1 vl 8: two issue cycles of 4, then drain
        begin_op(1'b0, 14'h010, 14'h0001, 7'd8, s);
        for (int i = 0; i < 4; i++) exp_ld(s + 1, i, i, 32'hD000_0010 + 32'(i));
        for (int i = 0; i < 4; i++) exp_ld(s + 2, i, i + 4, 32'hD000_0014 + 32'(i));
        exp_done(s + 3);
        end_op();
        chk("ld8_busy", 64'(busy), 64'h1);
        repeat (6) @(negedge core_clk);

        // load 0x001 stride 2 vl 4: banks 1,3 per cycle
        begin_op(1'b0, 14'h001, 14'h0002, 7'd4, s);
        exp_ld(s + 1, 0, 0, 32'hD000_0001);
        exp_ld(s + 1, 1, 1, 32'hD000_0003);
        exp_ld(s + 2, 0, 2, 32'hD000_0005);
        exp_ld(s + 2, 1, 3, 32'hD000_0007);
        exp_done(s + 3);
        end_op();
        repeat (6) @(negedge core_clk);

        // load 0x005 stride -1 vl 5: addrs 5,4,3,2 then 1
        begin_op(1'b0, 14'h005, 14'h3FFF, 7'd5, s);
        for (int i = 0; i < 4; i++) exp_ld(s + 1, i, i, 32'hD000_0005 - 32'(i));
        exp_ld(s + 2, 0, 4, 32'hD000_0001);
        exp_done(s + 3);
        end_op();
        repeat (6) @(negedge core_clk);

        // load 0x020 stride 0 vl 2: one element per cycle, same word
        begin_op(1'b0, 14'h020, 14'h0000, 7'd2, s);
        exp_ld(s + 1, 0, 0, 32'hD000_0020);
        exp_ld(s + 2, 0, 1, 32'hD000_0020);
        exp_done(s + 3);
        end_op();
        repeat (6) @(negedge core_clk);

        // store 0x003 stride 4 vl 3: bank 3 only, one per cycle
        begin_op(1'b1, 14'h003, 14'h0004, 7'd3, s);
        exp_st(s,     3, 14'h003, 0);
        exp_st(s + 1, 3, 14'h007, 1);
        exp_st(s + 2, 3, 14'h00B, 2);
        exp_done(s + 3);
        end_op();
        repeat (6) @(negedge core_clk);

        // store 0x1FFE stride 1 vl 4: wraps, all four banks in one cycle
        begin_op(1'b1, 14'h1FFE, 14'h0001, 7'd4, s);
        exp_st(s, 0, 14'h0000, 2);
        exp_st(s, 1, 14'h0001, 3);
        exp_st(s, 2, 14'h1FFE, 0);
        exp_st(s, 3, 14'h1FFF, 1);
        exp_done(s + 1);
        end_op();
        repeat (6) @(negedge core_clk);

        // read back the wrapped store
        begin_op(1'b0, 14'h1FFE, 14'h0001, 7'd4, s);
        for (int i = 0; i < 4; i++) exp_ld(s + 1, i, i, 32'h5700_0000 | 32'(i));
        exp_done(s + 2);
        end_op();
        repeat (6) @(negedge core_clk);

        // vl=0: done next cycle, no access, busy stays low
        begin_op(1'b0, 14'h030, 14'h0001, 7'd0, s);
        exp_done(s);
        end_op();
        chk("vl0_busy", 64'(busy), 64'h0);
        repeat (3) @(negedge core_clk);

        // store 0x040 stride 4 vl 2 with a second start while busy
        begin_op(1'b1, 14'h040, 14'h0004, 7'd2, s);
        exp_st(s,     0, 14'h040, 0);
        exp_st(s + 1, 0, 14'h044, 1);
        exp_done(s + 2);
        end_op();
        chk("st2_busy", 64'(busy), 64'h1);
        is_store  = 1'b0;
        base_addr = 14'h100;
        stride    = 14'h0001;
        vl        = 7'd4;
        start     = 1'b1;
        @(negedge core_clk);
        start = 1'b0;
        repeat (6) @(negedge core_clk);

        // reset in the first issue cycle of a load
        begin_op(1'b0, 14'h010, 14'h0001, 7'd8, s);
        end_op();
        chk("abort_addr", 64'(data_addr), 64'h010);
        #2 rst = 1'b1;
        #1 chk_all_zero("abort");
        @(negedge core_clk);
        rst = 1'b0;
        repeat (4) @(negedge core_clk);
        chk("abort_busy", 64'(busy), 64'h0);

        repeat (2) @(negedge core_clk);
        chk("sb_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
